// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing on clk_d with a p_tick pixel enable.
// Define SYNC_DELAY_EN to delay hsync/vsync by one pixel.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_d,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic ACT = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt;
  logic [9:0]    x_nx;
  logic [9:0]    y_nx;
  logic          hs_nx;
  logic          vs_nx;
  logic          hs_r;
  logic          vs_r;

  // With CLK_DIV=1 div_cnt stays 0 and p_tick is constantly 1.
  assign p_tick = (div_cnt == DIV_MAX);

  always_comb begin
    x_nx = pixel_x;
    y_nx = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_MAX) begin
        x_nx = '0;
        y_nx = (pixel_y == V_MAX) ? '0 : pixel_y + 10'd1;
      end else begin
        x_nx = pixel_x + 10'd1;
      end
    end
  end

  assign hs_nx = (x_nx >= HS_LO) && (x_nx <= HS_HI);
  assign vs_nx = (y_nx >= VS_LO) && (y_nx <= VS_HI);

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pixel_x     <= H_MAX;
      pixel_y     <= V_MAX;
      video_on    <= 1'b0;
      hs_r        <= ~ACT;
      vs_r        <= ~ACT;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= p_tick ? '0 : div_cnt + 1'b1;
      pixel_x     <= x_nx;
      pixel_y     <= y_nx;
      video_on    <= (x_nx < H_VIS) && (y_nx < V_VIS);
      hs_r        <= hs_nx ? ACT : ~ACT;
      vs_r        <= vs_nx ? ACT : ~ACT;
      frame_start <= p_tick && (x_nx == '0) && (y_nx == '0);
    end
  end

`ifdef SYNC_DELAY_EN
  logic hs_d;
  logic vs_d;

  // One pixel of lag lines sync up with pixel_gen's registered RGB.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      hs_d <= ~ACT;
      vs_d <= ~ACT;
    end else if (p_tick) begin
      hs_d <= hs_r;
      vs_d <= vs_r;
    end
  end

  assign hsync = hs_d;
  assign vsync = vs_d;
`else
  assign hsync = hs_r;
  assign vsync = vs_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, reduced CLK_DIV=3 and CLK_DIV=1 rasters
// checked every clk_d against an arithmetic raster model.
module tb_vga_sync_gen;

  logic clk_d = 1'b0;
  always #5 clk_d = ~clk_d;

  logic       rst_d, rst_s, rst_1;
  logic       pt_d, pt_s, pt_1;
  logic [9:0] x_d, x_s, x_1, y_d, y_s, y_1;
  logic       vo_d, vo_s, vo_1;
  logic       hs_d, hs_s, hs_1;
  logic       vs_d, vs_s, vs_1;
  logic       fs_d, fs_s, fs_1;

  int vectors = 0;
  int miscompares = 0;

  vga_sync_gen dut (
    .clk_d(clk_d), .rst_n(rst_d), .p_tick(pt_d),
    .pixel_x(x_d), .pixel_y(y_d), .video_on(vo_d),
    .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) dut_s (
    .clk_d(clk_d), .rst_n(rst_s), .p_tick(pt_s),
    .pixel_x(x_s), .pixel_y(y_s), .video_on(vo_s),
    .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
  ) dut_1 (
    .clk_d(clk_d), .rst_n(rst_1), .p_tick(pt_1),
    .pixel_x(x_1), .pixel_y(y_1), .video_on(vo_1),
    .hsync(hs_1), .vsync(vs_1), .frame_start(fs_1)
  );

  // Expected outputs after t clk_d edges out of reset:
  // {p_tick, x, y, video_on, hsync, vsync, frame_start}
  function automatic logic [24:0] model(
    int t, int cd, int ha, int hfp, int hsw, int hbp,
    int va, int vfp, int vsw, int vbp, bit pol);
    int ht, vt, ticks, k, ks, x, y, sx, sy;
    bit pt, vid, hs, vs, fs;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    ticks = t / cd;
    pt = ((t % cd) == cd - 1);
    if (ticks == 0) begin
      x = ht - 1; y = vt - 1;
      vid = 0; fs = 0;
    end else begin
      k = (ticks - 1) % (ht * vt);
      x = k % ht; y = k / ht;
      vid = (x < ha) && (y < va);
      fs = (k == 0) && ((t % cd) == 0);
    end
`ifdef SYNC_DELAY_EN
    ks = (ticks >= 2) ? (ticks - 2) % (ht * vt) : -1;
`else
    ks = (ticks >= 1) ? (ticks - 1) % (ht * vt) : -1;
`endif
    hs = 0; vs = 0;
    if (ks >= 0) begin
      sx = ks % ht; sy = ks / ht;
      hs = (sx >= ha + hfp) && (sx < ha + hfp + hsw);
      vs = (sy >= va + vfp) && (sy < va + vfp + vsw);
    end
    if (!pol) begin
      hs = !hs; vs = !vs;
    end
    return {pt, 10'(x), 10'(y), vid, hs, vs, fs};
  endfunction

  task automatic chk(string tag, logic [24:0] obs, logic [24:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int t_d = 0, t_s = 0, t_1 = 0;
  int hold_d = 0, hold_s = 0, hold_1 = 0;

  task automatic check_all();
    chk("dflt", {pt_d, x_d, y_d, vo_d, hs_d, vs_d, fs_d},
        model(t_d, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0));
    chk("cd3", {pt_s, x_s, y_s, vo_s, hs_s, vs_s, fs_s},
        model(t_s, 3, 20, 4, 6, 5, 10, 2, 2, 3, 1));
    chk("cd1", {pt_1, x_1, y_1, vo_1, hs_1, vs_1, fs_1},
        model(t_1, 1, 20, 4, 6, 5, 10, 2, 2, 3, 0));
  endtask

  initial begin
    rst_d = 1'b0; rst_s = 1'b0; rst_1 = 1'b0;
    repeat (3) @(posedge clk_d);
    #1;
    check_all();
    rst_d = 1'b1; rst_s = 1'b1; rst_1 = 1'b1;
    #1;
    check_all();

    for (int cyc = 0; cyc < 9000; cyc++) begin
      @(posedge clk_d);
      #1;
      if (rst_d) t_d++;
      if (rst_s) t_s++;
      if (rst_1) t_1++;

      // Default raster: reset mid-pixel at (300,1).
      if (rst_d && t_d == 4405) begin
        rst_d = 1'b0; t_d = 0; hold_d = 2;
      end else if (!rst_d && --hold_d <= 0) begin
        rst_d = 1'b1;
      end

      if (rst_s && $urandom_range(0, 2999) == 0) begin
        rst_s = 1'b0; t_s = 0; hold_s = $urandom_range(1, 3);
      end else if (!rst_s && --hold_s <= 0) begin
        rst_s = 1'b1;
      end

      if (rst_1 && $urandom_range(0, 2999) == 0) begin
        rst_1 = 1'b0; t_1 = 0; hold_1 = $urandom_range(1, 3);
      end else if (!rst_1 && --hold_1 <= 0) begin
        rst_1 = 1'b1;
      end

      #1;
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
